sl_transmitter: RTL and testbench

//  Upstream SL stage. Takes 32-bit words over a valid/ready handshake and drives them onto
//  the two-wire SL bus (zeroes/ones lines, idle high) that sl_receiver decodes.

---
 rtl/sl_tx_if.sv | 9 +
 rtl/sl_transmitter.sv | 103 ++++++++++
 tb/tb_sl_transmitter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sl_tx_if.sv
// sl_tx_if: valid/ready word handshake between an upstream producer and sl_transmitter.
interface sl_tx_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master(output tx_data, output tx_valid, input tx_ready);
    modport slave(input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sl_transmitter.sv
// sl_transmitter: serialises handshaked words onto the two-wire SL bus, LSB first, odd parity, stop symbol.
module sl_transmitter #(
    parameter int CONFIG_WIDTH = 16,
    parameter int PULSE_LEN    = 8,
    parameter int GAP_LEN      = 8,
    parameter int WORD_GAP     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CONFIG_WIDTH-1:0] wr_config_w,
    input  logic                    wr_enable,
    output logic [CONFIG_WIDTH-1:0] r_config_w,
    sl_tx_if.slave                  tx,
    output logic                    serial_line_zeroes,
    output logic                    serial_line_ones,
    output logic                    tx_busy,
    output logic                    word_sent
);
    localparam int CMAX = (PULSE_LEN > GAP_LEN) ? ((PULSE_LEN > WORD_GAP) ? PULSE_LEN : WORD_GAP)
                                                : ((GAP_LEN > WORD_GAP) ? GAP_LEN : WORD_GAP);
    localparam int CW = $clog2(CMAX);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PULSE      = 3'd1;
    localparam logic [2:0] GAP        = 3'd2;
    localparam logic [2:0] STOP_PULSE = 3'd3;
    localparam logic [2:0] STOP_GAP   = 3'd4;
    localparam logic [2:0] WORDGAP    = 3'd5;

    logic [2:0]    state, next_state;
    logic [CW-1:0] cnt, len_m1;
    logic [5:0]    sym, nsym, bq, n;
    logic [32:0]   sh, frame_data, frame_word;
    logic [31:0]   buf_data;
    logic          buf_full, cfg_ok, par, last, start;

    assign tx.tx_ready = !buf_full;

    always_comb begin
        bq         = wr_config_w[6:1];
        n          = r_config_w[6:1];
        cfg_ok     = wr_enable && !tx_busy && state == IDLE && !buf_full && !bq[0] && bq >= 6'd8 && bq <= 6'd32;
        frame_data = {1'b0, buf_data} & ((33'h1 << n) - 33'h1);
        par        = ~^frame_data ^ r_config_w[7];
        frame_word = frame_data | ({32'b0, par} << n);
        len_m1     = (state == PULSE || state == STOP_PULSE) ? CW'(PULSE_LEN - 1)
                   : (state == WORDGAP) ? CW'(WORD_GAP - 1) : CW'(GAP_LEN - 1);
        last       = cnt == len_m1;
        start      = state == IDLE || (state == WORDGAP && last);
        next_state = (state == PULSE) ? GAP
                   : (state == GAP) ? ((sym == nsym) ? STOP_PULSE : PULSE)
                   : (state == STOP_PULSE) ? STOP_GAP : WORDGAP;
    end

    // Line/status registers follow the state one cycle later, so every symbol keeps its full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_config_w         <= CONFIG_WIDTH'(16'h0010);
            state              <= IDLE;
            cnt                <= '0;
            sym                <= '0;
            nsym               <= '0;
            sh                 <= '0;
            buf_data           <= '0;
            buf_full           <= 1'b0;
            serial_line_zeroes <= 1'b1;
            serial_line_ones   <= 1'b1;
            tx_busy            <= 1'b0;
            word_sent          <= 1'b0;
        end else begin
            if (cfg_ok) r_config_w <= wr_config_w;
            if (tx.tx_valid && tx.tx_ready) begin
                buf_data <= tx.tx_data;
                buf_full <= 1'b1;
            end
            serial_line_zeroes <= !((state == PULSE && !sh[0]) || state == STOP_PULSE);
            serial_line_ones   <= !((state == PULSE && sh[0]) || state == STOP_PULSE);
            tx_busy            <= state != IDLE;
            word_sent          <= state == WORDGAP && last;
            if (start) begin
                cnt <= '0;
                if (buf_full) begin
                    sh       <= frame_word;
                    nsym     <= n;
                    sym      <= '0;
                    state    <= PULSE;
                    buf_full <= 1'b0;
                end else begin
                    state <= IDLE;
                end
            end else if (last) begin
                cnt   <= '0;
                state <= next_state;
                if (state == GAP) begin
                    sh  <= sh >> 1;
                    sym <= sym + 6'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter: randomized frame checks against a cycle-level waveform model built from the bus rules.
module tb_sl_transmitter;
  localparam int PL = 8;
  localparam int GL = 8;
  localparam int WG = 16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wr_config_w = '0;
  logic        wr_enable = 1'b0;
  logic [15:0] r_config_w;
  logic        z, o, busy, ws;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] cfg = 16'h0010;
  logic [4:0]  obs[$];
  logic [4:0]  exp_q[$];
  sl_tx_if tx_if();
  sl_transmitter dut (
    .clk(clk), .rst_n(rst_n), .wr_config_w(wr_config_w), .wr_enable(wr_enable),
    .r_config_w(r_config_w), .tx(tx_if), .serial_line_zeroes(z), .serial_line_ones(o),
    .tx_busy(busy), .word_sent(ws)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  function automatic int frame_len(input int n);
    return (n + 2) * (PL + GL) + WG;
  endfunction
  function automatic void add_frame(input logic [31:0] d, input int n, input logic pinj, input int rdy_lo);
    logic [31:0] m;
    logic p, b, lz, lo;
    int k;
    m = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    p = (($countones(d & m) % 2) == 0) ^ pinj;
    k = 0;
    for (int s = 0; s <= n + 1; s++) begin
      b  = (s < n) ? d[s & 31] : p;
      lz = (s == n + 1) ? 1'b0 : b;
      lo = (s == n + 1) ? 1'b0 : !b;
      for (int c = 0; c < PL + GL; c++) begin
        exp_q.push_back({k >= rdy_lo, (c < PL) ? lz : 1'b1, (c < PL) ? lo : 1'b1, 1'b0, 1'b1});
        k++;
      end
    end
    for (int c = 0; c < WG; c++) begin
      exp_q.push_back({k >= rdy_lo, 1'b1, 1'b1, c == WG - 1, 1'b1});
      k++;
    end
  endfunction
  function automatic void add_idle(input int k);
    for (int i = 0; i < k; i++) exp_q.push_back(5'b11100);
  endfunction
  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= obs.size()) return i;
      if (obs[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction
  function automatic int count_ws();
    int c = 0;
    foreach (obs[i]) if (obs[i][1]) c++;
    return c;
  endfunction
  task automatic capture(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      tx_if.tx_valid = 1'b0;
      obs.push_back({tx_if.tx_ready, z, o, ws, busy});
    end
  endtask
  task automatic write_cfg(input logic [15:0] v);
    wr_config_w = v;
    wr_enable   = 1'b1;
    @(posedge clk);
    #1;
    wr_enable = 1'b0;
  endtask
  task automatic test_frame(input string name, input logic [31:0] d, input int n, input logic pinj,
                            input logic wr, input logic [15:0] cv);
    int idx, pulses;
    obs.delete();
    exp_q.delete();
    add_frame(d, n, pinj, 0);
    add_idle(4);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    wr_config_w    = cv;
    wr_enable      = wr;
    @(posedge clk);
    #1;
    tx_if.tx_valid = 1'b0;
    wr_enable      = 1'b0;
    tests++;
    if (tx_if.tx_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s accept: ready=%b busy=%b, required ready=0 busy=0", name, tx_if.tx_ready, busy);
    end
    if (wr) begin
      tests++;
      if (r_config_w !== cv) begin
        fails++;
        $display("FAIL %s cfg_with_word: got %h, required %h", name, r_config_w, cv);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if ({tx_if.tx_ready, z, o, busy, ws} !== 5'b11100) begin
      fails++;
      $display("FAIL %s load_cycle: {rdy,z,o,busy,ws}=%b, required 11100", name, {tx_if.tx_ready, z, o, busy, ws});
    end
    capture(frame_len(n) + 4);
    idx = first_diff();
    tests++;
    if (idx != -1) begin
      fails++;
      $display("FAIL %s waveform at frame cycle %0d: {rdy,z,o,ws,busy}=%b, required %b", name, idx, obs[idx], exp_q[idx]);
    end
    pulses = count_ws();
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL %s word_sent pulses: got %0d, required 1", name, pulses);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({z, o, tx_if.tx_ready, busy, ws} !== 5'b11100) begin
      fails++;
      $display("FAIL reset_outputs: {z,o,rdy,busy,ws}=%b, required 11100", {z, o, tx_if.tx_ready, busy, ws});
    end
    tests++;
    if (r_config_w !== 16'h0010) begin
      fails++;
      $display("FAIL reset_config: got %h, required 0010", r_config_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({z, o, tx_if.tx_ready, busy, ws} !== 5'b11100) begin
      fails++;
      $display("FAIL idle_outputs: {z,o,rdy,busy,ws}=%b, required 11100", {z, o, tx_if.tx_ready, busy, ws});
    end
    tests++;
    if (r_config_w !== 16'h0010) begin
      fails++;
      $display("FAIL idle_config: got %h, required 0010", r_config_w);
    end
  endtask
  task automatic test_basic();
    test_frame("a5", 32'h0000_00A5, 8, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) test_frame("rand_n8", $urandom, 8, 1'b0, 1'b0, 16'h0);
  endtask
  task automatic test_back_to_back();
    int idx, pulses, len;
    len = frame_len(8);
    obs.delete();
    exp_q.delete();
    add_frame(32'h3C, 8, 1'b0, len - 1);
    add_frame(32'h01, 8, 1'b0, 0);
    add_idle(4);
    tx_if.tx_data  = 32'h3C;
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_if.tx_valid = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (tx_if.tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b ready_after_load: got %b, required 1", tx_if.tx_ready);
    end
    tx_if.tx_data  = 32'h01;
    tx_if.tx_valid = 1'b1;
    capture(2 * len + 4);
    idx = first_diff();
    tests++;
    if (idx != -1) begin
      fails++;
      $display("FAIL b2b waveform at cycle %0d: {rdy,z,o,ws,busy}=%b, required %b", idx, obs[idx], exp_q[idx]);
    end
    pulses = count_ws();
    tests++;
    if (pulses != 2) begin
      fails++;
      $display("FAIL b2b word_sent pulses: got %0d, required 2", pulses);
    end
  endtask
  task automatic test_config();
    logic [15:0] bad[3] = '{16'h000E, 16'h0044, 16'h000C};
    logic [15:0] v;
    int idx, n;
    logic pinj;
    foreach (bad[i]) begin
      write_cfg(bad[i]);
      tests++;
      if (r_config_w !== cfg) begin
        fails++;
        $display("FAIL cfg_reject %h: got %h, required %h", bad[i], r_config_w, cfg);
      end
    end
    obs.delete();
    exp_q.delete();
    add_frame(32'h5A, 8, 1'b0, 0);
    add_idle(4);
    tx_if.tx_data  = 32'h5A;
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_if.tx_valid = 1'b0;
    @(posedge clk);
    #1;
    capture(3);
    wr_config_w = 16'h0020;
    wr_enable   = 1'b1;
    capture(1);
    wr_enable = 1'b0;
    tests++;
    if (r_config_w !== cfg) begin
      fails++;
      $display("FAIL cfg_busy_reject: got %h, required %h", r_config_w, cfg);
    end
    capture(frame_len(8));
    idx = first_diff();
    tests++;
    if (idx != -1) begin
      fails++;
      $display("FAIL cfg_busy waveform at cycle %0d: {rdy,z,o,ws,busy}=%b, required %b", idx, obs[idx], exp_q[idx]);
    end
    write_cfg(16'h0040);
    cfg = 16'h0040;
    tests++;
    if (r_config_w !== cfg) begin
      fails++;
      $display("FAIL cfg_accept_32: got %h, required %h", r_config_w, cfg);
    end
    test_frame("ones_n32", 32'hFFFF_FFFF, 32, 1'b0, 1'b0, 16'h0);
    cfg = 16'h00A0;
    test_frame("cfg_with_word", $urandom, 16, 1'b1, 1'b1, cfg);
    for (int i = 0; i < 4; i++) begin
      n    = 2 * $urandom_range(4, 16);
      pinj = 1'($urandom);
      v    = 16'($urandom);
      v[6:1] = 6'(n);
      v[7]   = pinj;
      write_cfg(v);
      cfg = v;
      tests++;
      if (r_config_w !== cfg) begin
        fails++;
        $display("FAIL cfg_rand_accept: got %h, required %h", r_config_w, cfg);
      end
      test_frame("rand_cfg", $urandom, n, pinj, 1'b0, 16'h0);
    end
  endtask
  task automatic test_pinj();
    int lows;
    write_cfg(16'h0090);
    cfg = 16'h0090;
    test_frame("pinj_zero", 32'h0, 8, 1'b1, 1'b0, 16'h0);
    lows = 0;
    foreach (obs[i]) if (!obs[i][2] && obs[i][3]) lows++;
    tests++;
    if (lows != 0) begin
      fails++;
      $display("FAIL pinj ones_low_cycles: got %0d, required 0", lows);
    end
  endtask
  task automatic test_reset_mid();
    logic [4:0] s;
    obs.delete();
    tx_if.tx_data  = $urandom;
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_if.tx_valid = 1'b0;
    @(posedge clk);
    #1;
    capture(4 * (PL + GL) + 4);
    s = obs[obs.size() - 1];
    tests++;
    if ((s[3] ^ s[2]) !== 1'b1) begin
      fails++;
      $display("FAIL mid_symbol4_active: {z,o}=%b, required one line low", s[3:2]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({z, o, tx_if.tx_ready, busy, ws} !== 5'b11100) begin
      fails++;
      $display("FAIL async_reset: {z,o,rdy,busy,ws}=%b, required 11100", {z, o, tx_if.tx_ready, busy, ws});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cfg = 16'h0010;
    @(posedge clk);
    #1;
    tests++;
    if (r_config_w !== cfg) begin
      fails++;
      $display("FAIL reset_mid_config: got %h, required %h", r_config_w, cfg);
    end
    test_frame("after_reset", $urandom, 8, 1'b0, 1'b0, 16'h0);
  endtask
  initial begin
    tx_if.tx_data  = '0;
    tx_if.tx_valid = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_config();
    test_pinj();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
